// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart block.
// Frame-state encoding and parity selectors used by TX (and later RX).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int frame_bits(
      input int data_bits,
      input int parity,
      input int stop_bits
   );
      return 1 + data_bits
             + ((parity != PAR_NONE) ? 1 : 0)
             + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled.
// tick_o marks the last clock of each bit period.
module uart_baud_gen #(
   parameter int CLK_DIV = 234
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick_o = en_i & (cnt_q == LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_serout.sv
// UART transmit serializer: holding register + shifter, LSB first.
// All outputs are registered; serout_o trails the FSM state by one clock.
module uart_serout #(
   parameter int CLK_DIV   = 234,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 serout_o,
   output logic                 busy_o,
   output logic                 bit_tick_o
);

   import uart_pkg::*;

   localparam int BW = $clog2(DATA_BITS + 1);

   state_t state_q, state_n;

   logic [DATA_BITS-1:0] hold_q, hold_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_n;
   logic                 hold_full_q, hold_full_n;
   logic                 par_q, par_n;
   logic                 serout_q, serout_n;
   logic                 ready_q, busy_q, tick_q;
   logic                 tick, accept, load;

   uart_baud_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_baud (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (state_q == IDLE),
      .en_i   (state_q != IDLE),
      .tick_o (tick)
   );

   // ready_q mirrors ~hold_full, so accept only ever hits an empty hold
   assign accept = valid_i & ready_q;

   always_comb begin
      state_n     = state_q;
      hold_n      = hold_q;
      hold_full_n = hold_full_q;
      shift_n     = shift_q;
      par_n       = par_q;
      bit_cnt_n   = bit_cnt_q;
      load        = 1'b0;

      if (accept) begin
         hold_n      = data_i;
         hold_full_n = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (hold_full_q) load = 1'b1;
         end
         START: begin
            if (tick) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shift_n = shift_q >> 1;
               if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                  state_n = (PARITY != PAR_NONE) ?
                            uart_pkg::PARITY : STOP;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt_q + 1'b1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (tick) begin
               state_n   = STOP;
               bit_cnt_n = '0;
            end
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                  if (hold_full_q) load = 1'b1;
                  else state_n = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // hold -> shifter; from STOP this chains frames with no idle gap
      if (load) begin
         shift_n     = hold_q;
         par_n       = (PARITY == PAR_EVEN) ? ^hold_q : ~^hold_q;
         hold_full_n = 1'b0;
         bit_cnt_n   = '0;
         state_n     = START;
      end
   end

   always_comb begin
      serout_n = 1'b1;
      unique case (state_q)
         START:            serout_n = 1'b0;
         DATA:             serout_n = shift_q[0];
         uart_pkg::PARITY: serout_n = par_q;
         default:          serout_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         bit_cnt_q   <= '0;
         serout_q    <= 1'b1;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         hold_q      <= hold_n;
         hold_full_q <= hold_full_n;
         shift_q     <= shift_n;
         par_q       <= par_n;
         bit_cnt_q   <= bit_cnt_n;
         serout_q    <= serout_n;
         ready_q     <= ~hold_full_n;
         busy_q      <= (state_q != IDLE) | hold_full_q;
         tick_q      <= tick;
      end
   end

   assign ready_o    = ready_q;
   assign serout_o   = serout_q;
   assign busy_o     = busy_q;
   assign bit_tick_o = tick_q;

endmodule

// File: tb/tb_uart_serout.sv
// Bench for uart_serout: three instances (8N1/div4, 8E2/div4, 8N1/div234)
// checked against a frame-level model of the serial waveform.
module tb_uart_serout;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic [2:0] vld = 3'b000;

   logic ready_a, ser_a, busy_a, tick_a;
   logic ready_p, ser_p, busy_p, tick_p;
   logic ready_s, ser_s, busy_s, tick_s;

   logic obs_ready, obs_ser, obs_busy, obs_tick;

   int tests = 0;
   int fails = 0;
   int cur   = 0;

   always #5 clk = ~clk;

   uart_serout #(
      .CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vld[0]),
      .ready_o(ready_a), .serout_o(ser_a), .busy_o(busy_a),
      .bit_tick_o(tick_a)
   );

   uart_serout #(
      .CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
   ) dut_p (
      .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vld[1]),
      .ready_o(ready_p), .serout_o(ser_p), .busy_o(busy_p),
      .bit_tick_o(tick_p)
   );

   uart_serout #(
      .CLK_DIV(234), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) dut_s (
      .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vld[2]),
      .ready_o(ready_s), .serout_o(ser_s), .busy_o(busy_s),
      .bit_tick_o(tick_s)
   );

   always_comb begin
      case (cur)
         1: {obs_ready, obs_ser, obs_busy, obs_tick} =
               {ready_p, ser_p, busy_p, tick_p};
         2: {obs_ready, obs_ser, obs_busy, obs_tick} =
               {ready_s, ser_s, busy_s, tick_s};
         default: {obs_ready, obs_ser, obs_busy, obs_tick} =
               {ready_a, ser_a, busy_a, tick_a};
      endcase
   end

   // Reference: the line levels of one frame, one entry per bit period.
   function automatic logic [31:0] model_frame(
      input  logic [7:0] d,
      input  int         par,
      input  int         sb,
      output int         n
   );
      logic [31:0] f;
      f = '0;
      n = 0;
      f[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         f[n] = d[i];
         n++;
      end
      if (par != 0) begin
         f[n] = (par == 2) ? ^d : ~^d;
         n++;
      end
      for (int s = 0; s < sb; s++) begin
         f[n] = 1'b1;
         n++;
      end
      return f;
   endfunction

   // Drive one byte on instance sel; returns just after the accept edge.
   task automatic drive(input int sel, input logic [7:0] d,
                        output bit timeout);
      int n;
      n = 0;
      timeout = 1'b0;
      cur = sel;
      @(negedge clk);
      din = d;
      vld[sel] = 1'b1;
      while (obs_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) timeout = 1'b1;
      @(posedge clk);
      #1 vld[sel] = 1'b0;
   endtask

   // Sampler: first sample taken now (caller sits on the first start-bit
   // negedge); records each bit's level, in-bit changes and tick placement.
   task automatic capture(input int nbits, input int div,
                          output logic [31:0] bits,
                          output int bad_width, output int bad_tick,
                          output int ticks);
      logic first;
      bits = '0;
      bad_width = 0;
      bad_tick = 0;
      ticks = 0;
      first = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < div; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            if (j == 0) first = obs_ser;
            else if (obs_ser !== first) bad_width++;
            if (obs_tick === 1'b1) ticks++;
            if (obs_tick !== (j == div - 1)) bad_tick++;
         end
         bits[i] = first;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vld = 3'b000;
      repeat (3) @(negedge clk);
      tests++;
      if ({ser_a, ready_a, busy_a, tick_a} !== 4'b1100) begin
         fails++;
         $display("FAIL reset_values got %b want 1100",
                  {ser_a, ready_a, busy_a, tick_a});
      end
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tests++;
         if ({ser_a, ready_a, busy_a, ser_p, ready_p, busy_p}
             !== 6'b110110) begin
            fails++;
            $display("FAIL idle_after_reset cyc %0d got %b want 110110",
                     c, {ser_a, ready_a, busy_a,
                         ser_p, ready_p, busy_p});
         end
      end
   endtask

   task automatic test_frame(input int sel, input int div, input int par,
                             input int sb, input logic [7:0] d);
      bit          to;
      logic [31:0] got, exp;
      int          n, bw, bt, nt;
      drive(sel, d, to);
      tests++;
      if (to) begin
         fails++;
         $display("FAIL accept_timeout got 1 want 0");
      end
      exp = model_frame(d, par, sb, n);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (obs_ser !== 1'b1) begin
         fails++;
         $display("FAIL start_latency got %b want 1", obs_ser);
      end
      @(negedge clk);
      capture(n, div, got, bw, bt, nt);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL frame_bits d=%h got %h want %h", d, got, exp);
      end
      tests++;
      if (bw != 0) begin
         fails++;
         $display("FAIL bit_width d=%h got %0d want 0", d, bw);
      end
      tests++;
      if (bt != 0 || nt != n) begin
         fails++;
         $display("FAIL bit_tick d=%h got %0d/%0d want %0d/0",
                  d, nt, bt, n);
      end
      tests++;
      if (obs_busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_last_clk got %b want 1", obs_busy);
      end
      @(negedge clk);
      tests++;
      if ({obs_busy, obs_ser, obs_ready} !== 3'b011) begin
         fails++;
         $display("FAIL frame_end got %b want 011",
                  {obs_busy, obs_ser, obs_ready});
      end
   endtask

   task automatic test_8n1();
      test_frame(0, 4, 0, 1, 8'h55);
      for (int k = 0; k < 5; k++)
         test_frame(0, 4, 0, 1, 8'($urandom_range(0, 255)));
   endtask

   task automatic test_parity();
      test_frame(1, 4, 2, 2, 8'h07);
      for (int k = 0; k < 3; k++)
         test_frame(1, 4, 2, 2, 8'($urandom_range(0, 255)));
   endtask

   task automatic test_slow();
      test_frame(2, 234, 0, 1, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0]  d1, d2;
      logic [31:0] got, exp, f2;
      int          n1, n2, bw, bt, nt, w;
      d1 = 8'hA5;
      d2 = 8'h3C;
      cur = 0;
      w = 0;
      @(negedge clk);
      din = d1;
      vld[0] = 1'b1;
      while (ready_a !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 din = d2;
      @(negedge clk);
      tests++;
      if (ready_a !== 1'b0) begin
         fails++;
         $display("FAIL b2b_ready_after_accept got %b want 0", ready_a);
      end
      @(negedge clk);
      tests++;
      if (ready_a !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ready_after_xfer got %b want 1", ready_a);
      end
      @(posedge clk);
      #1 vld[0] = 1'b0;
      @(negedge clk);
      tests++;
      if (ready_a !== 1'b0) begin
         fails++;
         $display("FAIL b2b_second_accept got %b want 0", ready_a);
      end
      exp = model_frame(d1, 0, 1, n1);
      f2  = model_frame(d2, 0, 1, n2);
      exp = exp | (f2 << n1);
      capture(n1 + n2, 4, got, bw, bt, nt);
      tests++;
      if (got !== exp || bw != 0) begin
         fails++;
         $display("FAIL b2b_stream got %h/%0d want %h/0", got, bw, exp);
      end
      tests++;
      if (bt != 0 || nt != n1 + n2) begin
         fails++;
         $display("FAIL b2b_ticks got %0d/%0d want %0d/0",
                  nt, bt, n1 + n2);
      end
      @(negedge clk);
      tests++;
      if ({busy_a, ser_a} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_end got %b want 01", {busy_a, ser_a});
      end
   endtask

   task automatic test_reset_mid(input logic [7:0] d);
      bit to;
      drive(0, d, to);
      tests++;
      if (to) begin
         fails++;
         $display("FAIL mid_accept_timeout got 1 want 0");
      end
      repeat (20) @(negedge clk);
      tests++;
      if ({ser_a, busy_a} !== {d[3], 1'b1}) begin
         fails++;
         $display("FAIL mid_pre_reset got %b want %b",
                  {ser_a, busy_a}, {d[3], 1'b1});
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({ser_a, ready_a, busy_a} !== 3'b110) begin
         fails++;
         $display("FAIL mid_async_reset got %b want 110",
                  {ser_a, ready_a, busy_a});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         tests++;
         if ({ser_a, ready_a, busy_a} !== 3'b110) begin
            fails++;
            $display("FAIL mid_no_resend cyc %0d got %b want 110",
                     c, {ser_a, ready_a, busy_a});
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_8n1();
      test_back_to_back();
      test_parity();
      test_reset_mid(8'hFF);
      test_reset_mid(8'h00);
      test_slow();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
